// File: rtl/z80_ctl_sequencer.sv
// -----------------------------------------------------------------------------
// z80_ctl_sequencer
//
// Drives the Z80 control inputs (nRESET, nWAIT, nINT, nNMI, nBUSRQ) for one
// CPU. It releases reset after a programmable number of clocks. It injects
// wait states into memory and I/O cycles. It raises a level interrupt that
// the CPU clears with an INTA cycle, produces a timed NMI pulse and runs the
// bus-request handshake. Every output is a flop, so each output changes one
// clock after the input that causes it.
//
// Optional feature macro: Z80_CTL_WAIT_EN
//   defined   - the wait-state FSM and its counter are built.
//   undefined - no wait logic is built. nWAIT is tied to 1, and MEM_WAIT and
//               IO_WAIT have no effect.
//
// Parameters
//   RESET_CYCLES  clocks nRESET stays low after reset falls (1..255)
//   MEM_WAIT      wait states per memory read/write cycle (0..15)
//   IO_WAIT       wait states per I/O cycle, INTA excluded (0..15)
//   NMI_PULSE     nNMI low width in clocks (1..15)
//
// Ports
//   clk          in   CPU clock. All logic uses the rising edge.
//   reset        in   synchronous, active-high reset
//   nM1, nMREQ, nIORQ, nRD, nWR, nBUSACK
//                in   CPU status pins, active-low
//   int_req      in   one-clock pulse that requests a maskable interrupt
//   nmi_req      in   one-clock pulse that requests an NMI
//   busrq_req    in   level input; the bus is requested while it is high
//   nRESET, nWAIT, nINT, nNMI, nBUSRQ
//                out  CPU control pins, active-low, registered
//   int_pending  out  interrupt is asserted and not yet acknowledged
//   bus_granted  out  busrq_req is high and nBUSACK was sampled low
//   cpu_running  out  the reset sequence is complete
// -----------------------------------------------------------------------------
module z80_ctl_sequencer #(
    parameter int unsigned RESET_CYCLES = 3,
    parameter int unsigned MEM_WAIT     = 0,
    parameter int unsigned IO_WAIT      = 0,
    parameter int unsigned NMI_PULSE    = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic nM1,
    input  logic nMREQ,
    input  logic nIORQ,
    input  logic nRD,
    input  logic nWR,
    input  logic nBUSACK,
    input  logic int_req,
    input  logic nmi_req,
    input  logic busrq_req,
    output logic nRESET,
    output logic nWAIT,
    output logic nINT,
    output logic nNMI,
    output logic nBUSRQ,
    output logic int_pending,
    output logic bus_granted,
    output logic cpu_running
);

    localparam logic [7:0] RESET_LAST = 8'(RESET_CYCLES);
    localparam logic [3:0] NMI_LOAD   = 4'(NMI_PULSE);

    typedef enum logic [0:0] {
        RST_HOLD = 1'b0,
        RST_RUN  = 1'b1
    } rst_state_t;

    rst_state_t  rst_state_r;
    logic [7:0]  rst_cnt_r;
    logic        nreset_r;
    logic        running_r;

    logic        pend_r;
    logic        nint_r;

    logic [3:0]  nmi_cnt_r;
    logic        nnmi_r;

    logic        nbusrq_r;
    logic        granted_r;

    // Every function other than the reset sequencer is held idle until the
    // CPU is running. The same condition also covers an external reset.
    logic        hold_s;
    // INTA is M1 together with IORQ. It acknowledges the interrupt and never
    // counts as an I/O cycle.
    logic        inta_s;

    assign hold_s = reset | ~running_r;
    assign inta_s = ~nM1 & ~nIORQ;

    // Reset sequencer: counts clocks after reset falls, then releases the CPU.
    // The release happens on edge RESET_CYCLES+1 after reset falls.
    always_ff @(posedge clk) begin
        if (reset) begin
            rst_state_r <= RST_HOLD;
            rst_cnt_r   <= 8'd0;
            nreset_r    <= 1'b0;
            running_r   <= 1'b0;
        end else begin
            case (rst_state_r)
                RST_HOLD: begin
                    if (rst_cnt_r == RESET_LAST) begin
                        rst_state_r <= RST_RUN;
                        nreset_r    <= 1'b1;
                        running_r   <= 1'b1;
                    end else begin
                        rst_cnt_r   <= rst_cnt_r + 8'd1;
                    end
                end
                RST_RUN: begin
                    nreset_r  <= 1'b1;
                    running_r <= 1'b1;
                end
                default: begin
                    rst_state_r <= RST_HOLD;
                    rst_cnt_r   <= 8'd0;
                    nreset_r    <= 1'b0;
                    running_r   <= 1'b0;
                end
            endcase
        end
    end

    // Interrupt latch. If a new request and INTA arrive on the same edge,
    // the new request wins and the interrupt stays pending.
    always_ff @(posedge clk) begin
        if (hold_s) begin
            pend_r <= 1'b0;
            nint_r <= 1'b1;
        end else if (int_req) begin
            pend_r <= 1'b1;
            nint_r <= 1'b0;
        end else if (inta_s) begin
            pend_r <= 1'b0;
            nint_r <= 1'b1;
        end else begin
            pend_r <= pend_r;
            nint_r <= nint_r;
        end
    end

    // NMI pulse timer. A request is accepted only when the timer is idle.
    // A request during a pulse is ignored and does not lengthen the pulse.
    always_ff @(posedge clk) begin
        if (hold_s) begin
            nmi_cnt_r <= 4'd0;
            nnmi_r    <= 1'b1;
        end else if (nmi_cnt_r != 4'd0) begin
            nmi_cnt_r <= nmi_cnt_r - 4'd1;
            nnmi_r    <= (nmi_cnt_r == 4'd1);
        end else if (nmi_req) begin
            nmi_cnt_r <= NMI_LOAD;
            nnmi_r    <= 1'b0;
        end else begin
            nmi_cnt_r <= 4'd0;
            nnmi_r    <= 1'b1;
        end
    end

    // Bus request handshake. The grant follows the request level directly,
    // so dropping busrq_req clears the grant whatever nBUSACK is doing.
    always_ff @(posedge clk) begin
        if (hold_s) begin
            nbusrq_r  <= 1'b1;
            granted_r <= 1'b0;
        end else begin
            nbusrq_r  <= ~busrq_req;
            granted_r <= busrq_req & ~nBUSACK;
        end
    end

`ifdef Z80_CTL_WAIT_EN
    localparam logic [3:0] MEM_LOAD = 4'(MEM_WAIT);
    localparam logic [3:0] IO_LOAD  = 4'(IO_WAIT);

    typedef enum logic [1:0] {
        W_IDLE  = 2'd0,
        W_STALL = 2'd1,
        W_DONE  = 2'd2
    } wait_state_t;

    wait_state_t wait_state_r;
    logic [3:0]  wait_cnt_r;
    logic        nwait_r;

    logic        mem_start_s;
    logic        io_start_s;
    logic        strobes_idle_s;
    logic [3:0]  wait_load_s;

    assign mem_start_s    = ~nMREQ & (~nRD | ~nWR);
    assign io_start_s     = ~nIORQ & nM1;
    assign strobes_idle_s = nMREQ & nIORQ & nRD & nWR;

    // Selects the wait count for the cycle type being started.
    always_comb begin
        wait_load_s = 4'd0;
        if (mem_start_s) begin
            wait_load_s = MEM_LOAD;
        end else if (io_start_s) begin
            wait_load_s = IO_LOAD;
        end else begin
            wait_load_s = 4'd0;
        end
    end

    // Wait-state FSM. The counter is loaded with N-1 so that nWAIT is low
    // for exactly N clocks. DONE blocks a restart until every strobe is high
    // again, so each bus cycle is counted once.
    always_ff @(posedge clk) begin
        if (hold_s) begin
            wait_state_r <= W_IDLE;
            wait_cnt_r   <= 4'd0;
            nwait_r      <= 1'b1;
        end else begin
            case (wait_state_r)
                W_IDLE: begin
                    if (mem_start_s | io_start_s) begin
                        if (wait_load_s == 4'd0) begin
                            wait_state_r <= W_DONE;
                        end else begin
                            wait_state_r <= W_STALL;
                            wait_cnt_r   <= wait_load_s - 4'd1;
                            nwait_r      <= 1'b0;
                        end
                    end
                end
                W_STALL: begin
                    if (wait_cnt_r == 4'd0) begin
                        wait_state_r <= W_DONE;
                        nwait_r      <= 1'b1;
                    end else begin
                        wait_cnt_r   <= wait_cnt_r - 4'd1;
                    end
                end
                W_DONE: begin
                    nwait_r <= 1'b1;
                    if (strobes_idle_s) begin
                        wait_state_r <= W_IDLE;
                    end
                end
                default: begin
                    wait_state_r <= W_IDLE;
                    wait_cnt_r   <= 4'd0;
                    nwait_r      <= 1'b1;
                end
            endcase
        end
    end

    assign nWAIT = nwait_r;
`else
    // These strobes and wait parameters are only needed by the wait FSM.
    logic unused_s;
    assign unused_s = &{1'b0, nMREQ, nRD, nWR, 4'(MEM_WAIT), 4'(IO_WAIT)};
    assign nWAIT    = 1'b1;
`endif

    assign nRESET      = nreset_r;
    assign cpu_running = running_r;
    assign nINT        = nint_r;
    assign int_pending = pend_r;
    assign nNMI        = nnmi_r;
    assign nBUSRQ      = nbusrq_r;
    assign bus_granted = granted_r;

endmodule
